// File: rtl/iscb_pkg.sv
// Shared helpers for the ISCB square-root lane array: result lane geometry
// and a lane slicer usable from both RTL and testbench code.
package iscb_pkg;

    // Widest flattened result bus the slicer helper accepts.
    localparam int unsigned RES_MAX_W = 1024;

    // Bits per result lane: a full window of ones (2^win_log2) must fit.
    function automatic int unsigned res_lane_w(input int unsigned win_log2);
        return win_log2 + 1;
    endfunction

    // Extract lane `lane` from a flattened (zero-extended) result bus.
    function automatic int unsigned lane_result(input logic [RES_MAX_W-1:0] res,
                                                input int unsigned          lane,
                                                input int unsigned          win_log2);
        logic [RES_MAX_W-1:0] s;
        s = res >> (lane * res_lane_w(win_log2));
        return s[31:0] & ((32'd1 << res_lane_w(win_log2)) - 32'd1);
    endfunction

endpackage

// File: rtl/iscb_sqrt_lane.sv
// One ISCB square-root lane: a toggle feeding a correlated divider whose
// quotient shift register selects between the input stream and constant 1.
module iscb_sqrt_lane
    import iscb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WIN_LOG2 = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic in,
    output logic out
);

    if (DEPTH < 2 || WIN_LOG2 < 1) begin : g_cfg_err
        $error("iscb_sqrt_lane: DEPTH must be >= 2 and WIN_LOG2 >= 1");
    end

    logic             tog_q, tog_d;
    logic [DEPTH-1:0] sr_q, sr_d;
    logic             divisor;

    // Output select, divider enable and next-state for toggle / quotient register.
    always_comb begin
        out     = sr_q[DEPTH-1] ? in : 1'b1;
        divisor = tog_q | out;
        tog_d   = tog_q;
        sr_d    = sr_q;
        if (clr) begin
            tog_d = 1'b0;
            sr_d  = '0;
        end else if (en) begin
            tog_d = ~tog_q;
            if (divisor) begin
                sr_d = {sr_q[DEPTH-2:0], tog_q};
            end
        end
    end

    // Lane state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_q <= 1'b0;
            sr_q  <= '0;
        end else begin
            tog_q <= tog_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/iscb_sqrt_array.sv
// CH-lane ISCB square-root array with stall enable, stream clear and a
// windowed ones-counter per lane that publishes a binary estimate.
module iscb_sqrt_array
    import iscb_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WIN_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [CH-1:0]              in,
    output logic [CH-1:0]              out,
    output logic [CH*(WIN_LOG2+1)-1:0] result,
    output logic                       res_valid
);

    localparam int unsigned RW = res_lane_w(WIN_LOG2);

    for (genvar c = 0; c < CH; c++) begin : g_lane
        iscb_sqrt_lane #(
            .DEPTH    (DEPTH),
            .WIN_LOG2 (WIN_LOG2)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .clr (clr),
            .in  (in[c]),
            .out (out[c])
        );
    end

    logic [WIN_LOG2-1:0]     win_cnt_q, win_cnt_d;
    logic [CH-1:0][RW-1:0]   acc_q, acc_d;
    logic [CH-1:0][RW-1:0]   result_q, result_d;
    logic                    res_valid_q, res_valid_d;
    logic                    win_last;

    // Window counting and per-lane accumulation; the final sample of a
    // window goes straight into result so the accumulator restarts at 0.
    always_comb begin
        win_cnt_d   = win_cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        res_valid_d = 1'b0;
        win_last    = (win_cnt_q == '1);
        if (clr) begin
            win_cnt_d = '0;
            acc_d     = '0;
        end else if (en) begin
            win_cnt_d = win_cnt_q + WIN_LOG2'(1);
            for (int unsigned c = 0; c < CH; c++) begin
                if (win_last) begin
                    result_d[c] = acc_q[c] + RW'(out[c]);
                    acc_d[c]    = '0;
                end else begin
                    acc_d[c] = acc_q[c] + RW'(out[c]);
                end
            end
            res_valid_d = win_last;
        end
    end

    // Shared window state; rst also clears the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q   <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign result    = result_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_iscb_sqrt_array.sv
// Self-checking bench for iscb_sqrt_array against a queue-based lane model.
module tb_iscb_sqrt_array;
    import iscb_pkg::*;

    localparam int unsigned CH       = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned WIN_LOG2 = 4;
    localparam int unsigned WIN      = 16;
    localparam int unsigned RW       = WIN_LOG2 + 1;

    logic              clk = 1'b0;
    logic              rst, en, clr;
    logic [CH-1:0]     in;
    logic [CH-1:0]     out;
    logic [CH*RW-1:0]  result;
    logic              res_valid;

    always #5 clk = ~clk;

    iscb_sqrt_array #(
        .CH       (CH),
        .DEPTH    (DEPTH),
        .WIN_LOG2 (WIN_LOG2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .in        (in),
        .out       (out),
        .result    (result),
        .res_valid (res_valid)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: history queue per lane, oldest quotient bit at [0].
    bit m_tog [CH];
    bit m_hist[CH][$];
    int m_acc [CH];
    int m_res [CH];
    int m_cnt;
    bit m_vld;

    function automatic bit m_out(input int unsigned c);
        return m_hist[c][0] ? in[c] : 1'b1;
    endfunction

    task automatic m_clear_lanes();
        for (int unsigned c = 0; c < CH; c++) begin
            m_tog[c] = 1'b0;
            m_hist[c].delete();
            for (int unsigned k = 0; k < DEPTH; k++) m_hist[c].push_back(1'b0);
            m_acc[c] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic m_step();
        bit o[CH];
        if (rst) begin
            m_clear_lanes();
            for (int unsigned c = 0; c < CH; c++) m_res[c] = 0;
            m_vld = 1'b0;
        end else if (clr) begin
            m_clear_lanes();
            m_vld = 1'b0;
        end else if (en) begin
            for (int unsigned c = 0; c < CH; c++) o[c] = m_out(c);
            for (int unsigned c = 0; c < CH; c++) begin
                if (m_tog[c] || o[c]) begin
                    void'(m_hist[c].pop_front());
                    m_hist[c].push_back(m_tog[c]);
                end
                m_tog[c] = ~m_tog[c];
                m_acc[c] += int'(o[c]);
            end
            m_cnt++;
            m_vld = (m_cnt == WIN);
            if (m_vld) begin
                for (int unsigned c = 0; c < CH; c++) begin
                    m_res[c] = m_acc[c];
                    m_acc[c] = 0;
                end
                m_cnt = 0;
            end
        end else begin
            m_vld = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int unsigned c = 0; c < CH; c++) begin
            chk($sformatf("out[%0d]", c), 32'(out[c]), 32'(m_out(c)));
            chk($sformatf("result[%0d]", c),
                lane_result(RES_MAX_W'(result), c, WIN_LOG2), m_res[c]);
        end
        chk("res_valid", 32'(res_valid), 32'(m_vld));
        if (res_valid === 1'b1) pulses++;
        @(posedge clk);
        m_step();
        #1;
    endtask

    // en_mode: 0 = always on, 1 = alternate starting on, 2 = random ~85%.
    task automatic run(input int n, input int p, input logic [CH-1:0] fmask,
                       input logic [CH-1:0] fval, input int en_mode);
        for (int i = 0; i < n; i++) begin
            for (int unsigned c = 0; c < CH; c++)
                in[c] = fmask[c] ? fval[c] : ($urandom_range(99) < p);
            case (en_mode)
                1:       en = ((i % 2) == 0);
                2:       en = ($urandom_range(99) < 85);
                default: en = 1'b1;
            endcase
            cycle();
        end
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    function automatic int unsigned res_of(input int unsigned c);
        return lane_result(RES_MAX_W'(result), c, WIN_LOG2);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; in = '0;
        m_clear_lanes();
        for (int unsigned c = 0; c < CH; c++) m_res[c] = 0;
        m_vld = 1'b0;
        @(posedge clk); m_step(); #1;
        cycle();
        chk("reset_out", 32'(out), 32'hF);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;

        // All-ones input: every window counts WIN on every lane.
        pulses = 0;
        run(48, 100, '0, '0, 0);
        idle(1);
        chk("ones_pulses", pulses, 3);
        for (int unsigned c = 0; c < CH; c++) chk($sformatf("ones_res[%0d]", c), res_of(c), WIN);

        // Lane 0 held at 0 from a fresh stream: out 1,1,1,1,1,0,1,0,... -> 10 ones.
        pulse_clr();
        run(16, 100, 4'b0001, 4'b0000, 0);
        idle(1);
        chk("zero_lane0", res_of(0), 32'd10);
        chk("zero_lane1", res_of(1), WIN);

        // Enable gaps: 32 cycles with en alternating give exactly one window.
        pulse_clr();
        pulses = 0;
        run(32, 100, '0, '0, 1);
        idle(1);
        chk("gap_pulses", pulses, 1);
        chk("gap_res0", res_of(0), WIN);

        // clr three cycles into a window; prior result is retained.
        run(3, 0, '0, '0, 0);
        pulses = 0;
        pulse_clr();
        chk("clr_keep_res0", res_of(0), WIN);
        run(WIN, 30, '0, '0, 0);
        idle(1);
        chk("clr_next_pulse", pulses, 1);

        // clr coincident with the final window sample: no pulse, no update.
        pulse_clr();
        run(WIN - 1, 100, '0, '0, 0);
        pulses = 0;
        en = 1'b1; clr = 1'b1;
        cycle();
        clr = 1'b0; en = 1'b0;
        idle(2);
        chk("clr_final_pulses", pulses, 0);

        // rst mid-window wipes result and returns out to all ones.
        run(5, 50, '0, '0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(1);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_out", 32'(out), 32'hF);
        chk("rst_valid", 32'(res_valid), 32'd0);

        // Bernoulli streams with lane 3 pinned to 1 to expose cross-lane coupling.
        run(160, 25, 4'b1000, 4'b1000, 0);
        idle(1);
        chk("indep_p25_lane3", res_of(3), WIN);
        run(160, 64, 4'b1000, 4'b1000, 2);
        idle(1);
        chk("indep_p64_lane3", res_of(3), WIN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
